int_arbiter: RTL
================

INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter N_SRC, default 4, SHALL set the number of interrupt sources (2..8).
REQ-002 Parameter ID_W, default 2, SHALL set the vector width; ID_W = ceil(log2(N_SRC)).
REQ-003 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port irq  input  N_SRC  SHALL carry the source request lines, synchronous to clk; a 0->1 transition is an event.
REQ-006 Port mask_we  input  1  SHALL be the mask register write strobe.
REQ-007 Port mask_d  input  N_SRC  SHALL be the mask write data; 1 = source masked.
REQ-008 Port int_ack  input  1  SHALL be the control-unit acknowledge, a one-cycle pulse from a microinstruction field.
REQ-009 Port eoi  input  1  SHALL be the end-of-interrupt pulse from the handler.
REQ-010 Port int  output  1  SHALL drive the control unit interrupt jump condition.
REQ-011 Port vector  output  ID_W  SHALL give the index of the source being requested or serviced.
REQ-012 Port in_service  output  1  SHALL be high while a handler is active.
REQ-013 Port pending  output  N_SRC  SHALL expose the pending register.
REQ-014 Port mask_q  output  N_SRC  SHALL expose the mask register.

Function
REQ-015 irq_prev register SHALL store irq each cycle; event[i] = irq[i] & ~irq_prev[i].
REQ-016 pending[i] SHALL be set the cycle after event[i], regardless of mask or state.
REQ-017 pending[i] SHALL be cleared only on the int_ack cycle in state REQ when vector == i; a simultaneous event[i] SHALL win (bit stays set).
REQ-018 mask_q SHALL load mask_d on the cycle after mask_we; masked pending bits SHALL be retained, not discarded.
REQ-019 eligible = pending & ~mask_q; winner SHALL be the lowest set index (source 0 highest priority).
REQ-020 FSM states SHALL be IDLE, REQ and SERVICE.
REQ-021 IDLE: if eligible != 0, vector SHALL load the winner and state SHALL go to REQ on the next edge; otherwise stay.
REQ-022 REQ: int SHALL be 1; vector SHALL be held; on int_ack, state SHALL go to SERVICE.
REQ-023 REQ: if the vectored source becomes masked (mask_q[vector] = 1) with no int_ack, state SHALL return to IDLE; int_ack in the same cycle takes priority.
REQ-024 SERVICE: int SHALL be 0, in_service SHALL be 1, vector SHALL be held; on eoi, state SHALL go to IDLE.
REQ-025 The arbiter SHALL not nest: a higher-priority event during SERVICE SHALL only set pending.
REQ-026 int_ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-027 Latency: an event sampled at edge k SHALL set pending after edge k+1 and raise int after edge k+2, if IDLE and unmasked.
REQ-028 After eoi, a still-eligible source SHALL re-raise int after 2 edges (IDLE one cycle, then REQ).

Reset
REQ-029 On rst low, asynchronously: state = IDLE, pending = 0, mask_q = all 1s (all masked), irq_prev = 0, vector = 0.
REQ-030 Outputs during and after reset SHALL be int = 0 and in_service = 0 until the conditions of REQ-021 are met.
REQ-031 Asserting rst mid-REQ or mid-SERVICE SHALL abort immediately, with no int_ack or eoi required.

Verification
REQ-032 Single source: mask = 4'b0000, irq[2] 0->1 -> int = 1 two edges later, vector = 2; int_ack -> int = 0, in_service = 1, pending[2] = 0; eoi -> in_service = 0.
REQ-033 Priority: irq[3] and irq[1] rise in the same cycle -> vector = 1 first; after ack and eoi, vector = 3 and int re-asserts.
REQ-034 Masking: mask = 4'b0010, irq[1] rises -> pending = 4'b0010, int stays 0; write mask = 0 -> int = 1 with vector = 1.
REQ-035 Withdrawal and collision: in REQ for source 0, write mask = 4'b0001 -> IDLE, int = 0, pending[0] still set; separately, event[0] in the int_ack cycle -> pending[0] remains 1.
REQ-036 Reset mid-service: in SERVICE, pull rst low -> int = 0, in_service = 0, pending = 0, mask_q = 4'b1111 without a clock edge.
REQ-037 Level hold: irq[0] held high for 10 cycles -> exactly one event; no second request after eoi.

Source files
------------

// File: rtl/int_arbiter.sv
// rtl/int_arbiter.sv - priority interrupt arbiter with mask register and single-level service FSM
module int_arbiter #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_d,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             int_req,
  output logic [ID_W-1:0]  vector,
  output logic             in_service,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask_q
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]       state;
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] evt;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] ack_clr;
  logic [ID_W-1:0]  winner;
  logic             any_eligible;

  // Rising-edge detect, eligibility and the pending bit retired by an acknowledge
  always_comb begin
    evt          = irq & ~irq_prev;
    eligible     = pending & ~mask_q;
    any_eligible = |eligible;
    ack_clr      = '0;
    if (state == REQ && int_ack) begin
      ack_clr = {{(N_SRC-1){1'b0}}, 1'b1} << vector;
    end
  end

  // Fixed priority: scan downward so the lowest set index is the last one written
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  // Edge history, pending latch (a new event beats a same-cycle clear) and mask register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev <= '0;
      pending  <= '0;
      mask_q   <= '1;
    end else begin
      irq_prev <= irq;
      pending  <= (pending & ~ack_clr) | evt;
      if (mask_we) begin
        mask_q <= mask_d;
      end
    end
  end

  // Request / service sequencing; vector is captured only when leaving IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      vector <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_eligible) begin
            vector <= winner;
            state  <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            state <= SERVICE;
          end else if (mask_q[vector]) begin
            state <= IDLE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign int_req    = (state == REQ);
  assign in_service = (state == SERVICE);

endmodule
